// File: rtl/control_sequencer_pkg.sv
// Shared control-unit definitions: state codes,
// opcodes and opcode field width.
package cpu_ctrl_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    S_FETCH    = 3'b000,
    S_DECODE   = 3'b001,
    S_WAIT_IN  = 3'b010,
    S_EXEC_IN  = 3'b011,
    S_EXEC_OUT = 3'b100,
    S_EXEC_DEC = 3'b101,
    S_EXEC_JNZ = 3'b110,
    S_HALT     = 3'b111
  } state_e;

  localparam logic [OP_W-1:0] OP_IN   = 3'b011;
  localparam logic [OP_W-1:0] OP_OUT  = 3'b100;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b101;
  localparam logic [OP_W-1:0] OP_JNZ  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer bus: ir/enter in, state/status out.
// master drives ir+enter, slave is the sequencer.
interface control_sequencer_if #(
  parameter int IR_W   = 8,
  parameter int ICNT_W = 16
);
  logic [IR_W-1:0]   ir;
  logic              enter;
  logic [2:0]        current_state;
  logic              halted;
  logic              instr_done;
  logic [ICNT_W-1:0] instr_count;

  modport master (
    output ir, enter,
    input  current_state, halted,
    input  instr_done, instr_count
  );

  modport slave (
    input  ir, enter,
    output current_state, halted,
    output instr_done, instr_count
  );
endinterface

// File: rtl/control_sequencer_sync.sv
// Enter-key synchroniser + rising-edge detector.
// Ports: clk, rst_n, d_i (async), level_o, rise_o.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 1 so a key held through reset
  // never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
endmodule

// File: rtl/control_sequencer.sv
// Accumulator-CPU sequencer: state register,
// next-state logic, retired-instr counter.
// Ports: clk, rst_n, bus (slave: ir, enter,
// current_state, halted, instr_done, instr_count).
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ICNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.slave  bus
);
  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic [ICNT_W-1:0] cnt_q, cnt_d;
  logic              ent_lvl, ent_rise;
  logic [OP_W-1:0]   op;
  logic              op_exec;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (bus.enter),
    .level_o (ent_lvl),
    .rise_o  (ent_rise)
  );

  assign op      = bus.ir[IR_W-1 -: OP_W];
  assign op_exec = op inside {OP_OUT, OP_DEC,
                              OP_JNZ, OP_HALT};

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op == OP_IN: state_d = S_WAIT_IN;
          op_exec: begin
            // EXEC_* codes equal their opcodes
            state_d = state_e'(op);
            done_d  = (op == OP_HALT);
          end
          default: begin
            state_d = S_FETCH;
            done_d  = 1'b1;
          end
        endcase
      end
      // Edge pulse lasts one cycle, so edges
      // outside WAIT_IN are simply lost.
      S_WAIT_IN:
        if (ent_rise && ent_lvl)
          state_d = S_EXEC_IN;
      S_EXEC_IN, S_EXEC_OUT,
      S_EXEC_DEC, S_EXEC_JNZ: begin
        state_d = S_FETCH;
        done_d  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  assign cnt_d = done_d ? cnt_q + ICNT_W'(1)
                        : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.instr_done    = done_q;
  assign bus.instr_count   = cnt_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Per-cycle expectations queued, checked at negedge.
module tb_control_sequencer;
  localparam int IR_W = 8;
  localparam int SYNC = 2;
  localparam int CW   = 4;

  localparam logic [2:0] FE = 3'b000;
  localparam logic [2:0] DE = 3'b001;
  localparam logic [2:0] WI = 3'b010;
  localparam logic [2:0] XI = 3'b011;
  localparam logic [2:0] XO = 3'b100;
  localparam logic [2:0] XD = 3'b101;
  localparam logic [2:0] XJ = 3'b110;
  localparam logic [2:0] HL = 3'b111;

  typedef struct {
    logic [2:0]    st;
    logic          dn;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  logic [CW-1:0] mcnt = '0;
  int nchk = 0;
  int nerr = 0;

  control_sequencer_if #(
    .IR_W(IR_W), .ICNT_W(CW)
  ) bus ();

  control_sequencer #(
    .IR_W(IR_W), .SYNC_STAGES(SYNC),
    .ICNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ":state"},
          32'(bus.current_state), 32'(e.st));
      chk({e.tag, ":done"},
          32'(bus.instr_done), 32'(e.dn));
      chk({e.tag, ":halted"},
          32'(bus.halted), 32'(e.st == HL));
      chk({e.tag, ":count"},
          32'(bus.instr_count), 32'(e.cnt));
    end
  end

  task automatic cyc(input logic [2:0] st,
                     input logic dn,
                     input string tag);
    exp_t e;
    if (dn) mcnt = mcnt + 1'b1;
    e.st = st;
    e.dn = dn;
    e.cnt = mcnt;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mcnt = '0;
    cyc(FE, 1'b0, "rst");
    rst_n = 1'b1;
  endtask

  function automatic logic [IR_W-1:0]
      mk_ir(input logic [2:0] op);
    logic [IR_W-4:0] lo;
    lo = IR_W'($urandom_range(0, 31));
    return {op, lo};
  endfunction

  // In WAIT_IN with synced enter low: wait n,
  // press, expect EXEC_IN after SYNC+1 edges.
  task automatic press(input int n,
                       input string tag);
    repeat (n) cyc(WI, 1'b0, tag);
    bus.enter = 1'b1;
    repeat (SYNC) cyc(WI, 1'b0, tag);
    cyc(XI, 1'b0, tag);
    cyc(FE, 1'b1, tag);
  endtask

  initial begin
    bus.ir = '0;
    bus.enter = 1'b0;
    do_reset();

    // 1: OUT
    bus.ir = mk_ir(3'b100);
    cyc(DE, 1'b0, "out");
    cyc(XO, 1'b0, "out");
    cyc(FE, 1'b1, "out");

    // 2: IN, long wait, then held key
    bus.ir = mk_ir(3'b011);
    cyc(DE, 1'b0, "in");
    repeat (11) cyc(WI, 1'b0, "in_wait");
    press(0, "in_go");
    cyc(DE, 1'b0, "in2");
    repeat (6) cyc(WI, 1'b0, "in2_held");
    bus.enter = 1'b0;
    press(3, "in2_go");

    // 3: key pulsed before WAIT_IN is dropped
    bus.ir = mk_ir(3'b100);
    cyc(DE, 1'b0, "pre");
    cyc(XO, 1'b0, "pre");
    bus.enter = 1'b1;
    bus.ir = mk_ir(3'b011);
    cyc(FE, 1'b1, "drop");
    bus.enter = 1'b0;
    cyc(DE, 1'b0, "drop");
    repeat (8) cyc(WI, 1'b0, "drop_wait");
    press(0, "drop_go");

    // 6: reset in WAIT_IN with key held
    bus.ir = mk_ir(3'b011);
    cyc(DE, 1'b0, "rwi");
    repeat (3) cyc(WI, 1'b0, "rwi");
    bus.enter = 1'b1;
    cyc(WI, 1'b0, "rwi");
    do_reset();
    cyc(DE, 1'b0, "rwi_rel");
    repeat (8) cyc(WI, 1'b0, "rwi_noexec");
    bus.enter = 1'b0;
    press(3, "rwi_go");

    // 5: NOP/DEC/JNZ loop, counter wrap
    do_reset();
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      int k;
      k = $urandom_range(0, 4);
      case (k)
        0, 1: begin
          bus.ir = mk_ir(3'(k + 1) - 3'd1
                         + 3'(k));
          cyc(DE, 1'b0, "nop");
          cyc(FE, 1'b1, "nop");
        end
        2: begin
          bus.ir = mk_ir(3'b101);
          cyc(DE, 1'b0, "dec");
          cyc(XD, 1'b0, "dec");
          cyc(FE, 1'b1, "dec");
        end
        default: begin
          bus.ir = mk_ir(3'b110);
          cyc(DE, 1'b0, "jnz");
          cyc(XJ, 1'b0, "jnz");
          cyc(FE, 1'b1, "jnz");
        end
      endcase
    end
    chk("wrap_count",
        32'(bus.instr_count), 32'd3);

    // 4: HALT, then reset out of it
    bus.ir = mk_ir(3'b111);
    cyc(DE, 1'b0, "halt");
    cyc(HL, 1'b1, "halt_in");
    repeat (50) cyc(HL, 1'b0, "halt_stay");
    do_reset();
    bus.ir = mk_ir(3'b100);
    cyc(DE, 1'b0, "post");
    cyc(XO, 1'b0, "post");
    cyc(FE, 1'b1, "post");

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end
endmodule
